// File: rtl/ipif_mst_responder_if.sv
// IPIF master command bus as seen between the DMA AXI-lite master port and a
// single-beat responder. Signal names follow the IPIF naming of the master core.
interface ipif_mst_responder_if;
    logic        IP2Bus_MstRd_Req;
    logic        IP2Bus_MstWr_Req;
    logic [31:0] IP2Bus_Mst_Addr;
    logic [3:0]  IP2Bus_Mst_BE;
    logic        IP2Bus_Mst_Lock;
    logic        IP2Bus_Mst_Reset;
    logic [31:0] IP2Bus_MstWr_d;
    logic        Bus2IP_Mst_CmdAck;
    logic        Bus2IP_Mst_Cmplt;
    logic        Bus2IP_Mst_Error;
    logic        Bus2IP_Mst_Rearbitrate;
    logic        Bus2IP_Mst_Timeout;
    logic [31:0] Bus2IP_MstRd_d;
    logic        Bus2IP_MstRd_src_rdy_n;
    logic        Bus2IP_MstWr_dst_rdy_n;

    modport master (
        output IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE,
               IP2Bus_Mst_Lock, IP2Bus_Mst_Reset, IP2Bus_MstWr_d,
        input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
               Bus2IP_Mst_Rearbitrate, Bus2IP_Mst_Timeout, Bus2IP_MstRd_d,
               Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n
    );

    modport slave (
        input  IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE,
               IP2Bus_Mst_Lock, IP2Bus_Mst_Reset, IP2Bus_MstWr_d,
        output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
               Bus2IP_Mst_Rearbitrate, Bus2IP_Mst_Timeout, Bus2IP_MstRd_d,
               Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n
    );
endinterface

// File: rtl/ipif_mst_responder.sv
// Single-beat IPIF master-command responder backed by a byte-enabled register
// bank, with programmable wait latency, bad-address errors and statistics.
module ipif_mst_responder #(
    parameter int          ADDR_WIDTH  = 6,
    parameter logic [31:0] BASE_ADDR   = 32'h7A00_0000,
    parameter int          WAIT_CYCLES = 2,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                 axi_clk,
    input  logic                 axi_resetn,
    ipif_mst_responder_if.slave  bus,
    output logic [CNT_WIDTH-1:0] stat_rd_cnt,
    output logic [CNT_WIDTH-1:0] stat_wr_cnt,
    output logic [CNT_WIDTH-1:0] stat_err_cnt
);
    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_WAIT,
        S_DATA,
        S_CMPLT
    } state_t;

    state_t                 state_reg;
    logic [31:0]            addr_reg;
    logic [3:0]             be_reg;
    logic                   is_wr_reg;
    logic [3:0]             wait_cnt_reg;
    logic                   cmd_ack_reg;
    logic                   cmplt_reg;
    logic                   error_reg;
    logic                   src_rdy_n_reg;
    logic                   dst_rdy_n_reg;
    logic [31:0]            rd_d_reg;
    logic [CNT_WIDTH-1:0]   rd_cnt_reg;
    logic [CNT_WIDTH-1:0]   wr_cnt_reg;
    logic [CNT_WIDTH-1:0]   err_cnt_reg;

    logic                   addr_good;
    logic [ADDR_WIDTH-1:0]  index;
    logic                   go_data;
    logic                   bank_we;
    logic [31:0]            rd_word;
    logic                   unused_lock;

    assign unused_lock = bus.IP2Bus_Mst_Lock;

    assign addr_good = (addr_reg[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]) &&
                       (addr_reg[1:0] == 2'b00);
    assign index     = addr_reg[ADDR_WIDTH+1:2];

    // DATA is entered straight from ACK only when no wait cycles are configured.
    assign go_data = ((state_reg == S_ACK) && addr_good && (WAIT_CYCLES == 0)) ||
                     ((state_reg == S_WAIT) && (wait_cnt_reg == 4'd0));

    // An abort during the DATA cycle itself drops the write.
    assign bank_we = (state_reg == S_DATA) && is_wr_reg && !bus.IP2Bus_Mst_Reset;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];

            always_ff @(posedge axi_clk or negedge axi_resetn) begin
                if (!axi_resetn) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i] <= 8'd0;
                    end
                end else if (bank_we && be_reg[gi]) begin
                    mem[index] <= bus.IP2Bus_MstWr_d[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = mem[index];
        end
    endgenerate

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_reg     <= S_IDLE;
            addr_reg      <= 32'd0;
            be_reg        <= 4'd0;
            is_wr_reg     <= 1'b0;
            wait_cnt_reg  <= 4'd0;
            cmd_ack_reg   <= 1'b0;
            cmplt_reg     <= 1'b0;
            error_reg     <= 1'b0;
            src_rdy_n_reg <= 1'b1;
            dst_rdy_n_reg <= 1'b1;
            rd_d_reg      <= 32'd0;
            rd_cnt_reg    <= '0;
            wr_cnt_reg    <= '0;
            err_cnt_reg   <= '0;
        end else begin
            cmd_ack_reg   <= 1'b0;
            cmplt_reg     <= 1'b0;
            error_reg     <= 1'b0;
            src_rdy_n_reg <= 1'b1;
            dst_rdy_n_reg <= 1'b1;

            if (bus.IP2Bus_Mst_Reset) begin
                state_reg <= S_IDLE;
            end else begin
                if (go_data) begin
                    state_reg <= S_DATA;
                    if (is_wr_reg) begin
                        dst_rdy_n_reg <= 1'b0;
                    end else begin
                        src_rdy_n_reg <= 1'b0;
                        rd_d_reg      <= rd_word;
                    end
                end

                case (state_reg)
                    S_IDLE: begin
                        // Write wins a tie; a held read is picked up on the next IDLE.
                        if (bus.IP2Bus_MstWr_Req || bus.IP2Bus_MstRd_Req) begin
                            is_wr_reg   <= bus.IP2Bus_MstWr_Req;
                            addr_reg    <= bus.IP2Bus_Mst_Addr;
                            be_reg      <= bus.IP2Bus_Mst_BE;
                            cmd_ack_reg <= 1'b1;
                            state_reg   <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        if (!addr_good) begin
                            cmplt_reg <= 1'b1;
                            error_reg <= 1'b1;
                            state_reg <= S_CMPLT;
                        end else if (WAIT_CYCLES != 0) begin
                            wait_cnt_reg <= WAIT_LOAD;
                            state_reg    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (wait_cnt_reg != 4'd0) begin
                            wait_cnt_reg <= wait_cnt_reg - 4'd1;
                        end
                    end
                    S_DATA: begin
                        cmplt_reg <= 1'b1;
                        state_reg <= S_CMPLT;
                    end
                    S_CMPLT: begin
                        if (error_reg) begin
                            err_cnt_reg <= err_cnt_reg + CNT_WIDTH'(1);
                        end else if (is_wr_reg) begin
                            wr_cnt_reg <= wr_cnt_reg + CNT_WIDTH'(1);
                        end else begin
                            rd_cnt_reg <= rd_cnt_reg + CNT_WIDTH'(1);
                        end
                        state_reg <= S_IDLE;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.Bus2IP_Mst_CmdAck      = cmd_ack_reg;
    assign bus.Bus2IP_Mst_Cmplt       = cmplt_reg;
    assign bus.Bus2IP_Mst_Error       = error_reg;
    assign bus.Bus2IP_Mst_Rearbitrate = 1'b0;
    assign bus.Bus2IP_Mst_Timeout     = 1'b0;
    assign bus.Bus2IP_MstRd_d         = rd_d_reg;
    assign bus.Bus2IP_MstRd_src_rdy_n = src_rdy_n_reg;
    assign bus.Bus2IP_MstWr_dst_rdy_n = dst_rdy_n_reg;

    assign stat_rd_cnt  = rd_cnt_reg;
    assign stat_wr_cnt  = wr_cnt_reg;
    assign stat_err_cnt = err_cnt_reg;
endmodule

// File: tb/tb_ipif_mst_responder.sv
// Bench for ipif_mst_responder: directed scenarios plus random single-beat
// traffic, checked every cycle against a transaction-level timeline model.
module tb_ipif_mst_responder;
    localparam int          AW    = 6;
    localparam logic [31:0] BASE  = 32'h7A00_0000;
    localparam int          W     = 2;
    localparam int          CW    = 16;
    localparam int          DEPTH = 1 << AW;
    localparam int          MAXC  = 8192;

    logic axi_clk    = 1'b0;
    logic axi_resetn = 1'b0;
    always #5 axi_clk = ~axi_clk;

    ipif_mst_responder_if bus_if();
    logic [CW-1:0] stat_rd_cnt, stat_wr_cnt, stat_err_cnt;

    ipif_mst_responder #(
        .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(W), .CNT_WIDTH(CW)
    ) dut (
        .axi_clk(axi_clk),
        .axi_resetn(axi_resetn),
        .bus(bus_if),
        .stat_rd_cnt(stat_rd_cnt),
        .stat_wr_cnt(stat_wr_cnt),
        .stat_err_cnt(stat_err_cnt)
    );

    int cyc = 0;
    always @(posedge axi_clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;
    int free_cyc = 0;

    // Expected-event timeline, indexed by cycle number.
    bit          e_ack[MAXC], e_cmplt[MAXC], e_err[MAXC], e_src[MAXC], e_dst[MAXC];
    bit          e_inc_rd[MAXC], e_inc_wr[MAXC], e_inc_err[MAXC];
    logic [31:0] e_rdd[MAXC];
    logic [31:0] mmem[DEPTH];
    logic [CW-1:0] m_rd = '0, m_wr = '0, m_err = '0;
    logic [31:0] m_rdd = 32'd0;

    // Observed DUT history for hand-computed spot checks.
    logic        h_ack[MAXC], h_cmplt[MAXC], h_err[MAXC], h_src[MAXC], h_dst[MAXC];
    logic [31:0] h_rdd[MAXC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return ((a >> (AW + 2)) == (BASE >> (AW + 2))) && (a[1:0] == 2'b00);
    endfunction

    // Places one transaction presented at cycle n on the timeline; returns the
    // first cycle at which the next request may be presented.
    function automatic int sched(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                                 input logic [31:0] data, input int n, input int abort_rel);
        int d;
        int idx;
        idx = int'((addr >> 2) % DEPTH);
        e_ack[n+1] = 1'b1;
        if (abort_rel > 0) return n + abort_rel + 1;
        if (!addr_ok(addr)) begin
            e_cmplt[n+2] = 1'b1;
            e_err[n+2] = 1'b1;
            e_inc_err[n+2] = 1'b1;
            return n + 3;
        end
        d = n + 2 + W;
        if (wr) begin
            e_dst[d] = 1'b1;
            for (int b = 0; b < 4; b++)
                if (be[b]) mmem[idx][8*b +: 8] = data[8*b +: 8];
            e_inc_wr[d+1] = 1'b1;
        end else begin
            e_src[d] = 1'b1;
            e_rdd[d] = mmem[idx];
            e_inc_rd[d+1] = 1'b1;
        end
        e_cmplt[d+1] = 1'b1;
        return d + 2;
    endfunction

    task automatic run_txn(input bit wr, input bit hold_rd, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] data,
                           input int abort_rel, output int n);
        while (cyc < free_cyc) tick();
        n = cyc;
        bus_if.IP2Bus_MstWr_Req = wr;
        bus_if.IP2Bus_MstRd_Req = !wr || hold_rd;
        bus_if.IP2Bus_Mst_Addr  = addr;
        bus_if.IP2Bus_Mst_BE    = be;
        bus_if.IP2Bus_MstWr_d   = data;
        bus_if.IP2Bus_Mst_Lock  = 1'($urandom_range(0, 1));
        free_cyc = sched(wr, addr, be, data, n, abort_rel);
        tick();
        bus_if.IP2Bus_MstWr_Req = 1'b0;
        if (!hold_rd) begin
            bus_if.IP2Bus_MstRd_Req = 1'b0;
            bus_if.IP2Bus_Mst_Addr  = $urandom;
            bus_if.IP2Bus_Mst_BE    = 4'($urandom);
        end
        if (abort_rel > 0) begin
            while (cyc < n + abort_rel) tick();
            bus_if.IP2Bus_Mst_Reset = 1'b1;
            tick();
            bus_if.IP2Bus_Mst_Reset = 1'b0;
        end
    endtask

    task automatic settle();
        while (cyc < free_cyc) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"},   bus_if.Bus2IP_Mst_CmdAck, 0);
        chk({tag, "_cmplt"}, bus_if.Bus2IP_Mst_Cmplt, 0);
        chk({tag, "_err"},   bus_if.Bus2IP_Mst_Error, 0);
        chk({tag, "_src"},   bus_if.Bus2IP_MstRd_src_rdy_n, 1);
        chk({tag, "_dst"},   bus_if.Bus2IP_MstWr_dst_rdy_n, 1);
        chk({tag, "_rdd"},   bus_if.Bus2IP_MstRd_d, 32'd0);
        chk({tag, "_rdcnt"}, stat_rd_cnt, 0);
        chk({tag, "_wrcnt"}, stat_wr_cnt, 0);
        chk({tag, "_errcnt"}, stat_err_cnt, 0);
    endtask

    always @(negedge axi_clk) begin : cmp
        int k;
        if (chk_en && cyc > 0 && cyc < MAXC) begin
            k = cyc;
            if (e_inc_rd[k-1])  m_rd++;
            if (e_inc_wr[k-1])  m_wr++;
            if (e_inc_err[k-1]) m_err++;
            if (e_src[k]) m_rdd = e_rdd[k];
            h_ack[k]   = bus_if.Bus2IP_Mst_CmdAck;
            h_cmplt[k] = bus_if.Bus2IP_Mst_Cmplt;
            h_err[k]   = bus_if.Bus2IP_Mst_Error;
            h_src[k]   = bus_if.Bus2IP_MstRd_src_rdy_n;
            h_dst[k]   = bus_if.Bus2IP_MstWr_dst_rdy_n;
            h_rdd[k]   = bus_if.Bus2IP_MstRd_d;
            chk("cmd_ack", bus_if.Bus2IP_Mst_CmdAck, e_ack[k]);
            chk("cmplt", bus_if.Bus2IP_Mst_Cmplt, e_cmplt[k]);
            chk("error", bus_if.Bus2IP_Mst_Error, e_err[k]);
            chk("src_rdy_n", bus_if.Bus2IP_MstRd_src_rdy_n, !e_src[k]);
            chk("dst_rdy_n", bus_if.Bus2IP_MstWr_dst_rdy_n, !e_dst[k]);
            chk("rd_d", bus_if.Bus2IP_MstRd_d, m_rdd);
            chk("stat_rd", stat_rd_cnt, m_rd);
            chk("stat_wr", stat_wr_cnt, m_wr);
            chk("stat_err", stat_err_cnt, m_err);
            chk("rearb_tmo", {bus_if.Bus2IP_Mst_Rearbitrate, bus_if.Bus2IP_Mst_Timeout}, 0);
        end
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog: simulation exceeded %0d cycles", MAXC);
        $fatal(1);
    end

    initial begin
        int n, n2, idx, r, ab, gap;
        logic [31:0] a;
        bit wr;

        for (int i = 0; i < DEPTH; i++) mmem[i] = 32'd0;
        bus_if.IP2Bus_MstRd_Req = 1'b0;
        bus_if.IP2Bus_MstWr_Req = 1'b0;
        bus_if.IP2Bus_Mst_Addr  = 32'd0;
        bus_if.IP2Bus_Mst_BE    = 4'd0;
        bus_if.IP2Bus_Mst_Lock  = 1'b0;
        bus_if.IP2Bus_Mst_Reset = 1'b0;
        bus_if.IP2Bus_MstWr_d   = 32'd0;

        tick();
        tick();
        check_reset_outputs("reset");
        axi_resetn = 1'b1;
        chk_en = 1'b1;
        free_cyc = cyc;

        // Write then read back, full word.
        run_txn(1, 0, 32'h7A00_0010, 4'hF, 32'hCAFE_F00D, 0, n);
        settle();
        chk("t1_ack_n1", h_ack[n+1], 1);
        chk("t1_dst_n4", h_dst[n+4], 0);
        chk("t1_cmplt_n5", h_cmplt[n+5], 1);
        chk("t1_err_n5", h_err[n+5], 0);
        run_txn(0, 0, 32'h7A00_0010, 4'h0, 32'd0, 0, n);
        settle();
        chk("t1_src_n4", h_src[n+4], 0);
        chk("t1_rdd_n4", h_rdd[n+4], 32'hCAFE_F00D);
        chk("t1_wrcnt", stat_wr_cnt, 1);
        chk("t1_rdcnt", stat_rd_cnt, 1);

        // Partial write with byte enables.
        run_txn(1, 0, 32'h7A00_0020, 4'hF, 32'h1122_3344, 0, n);
        run_txn(1, 0, 32'h7A00_0020, 4'b0101, 32'hAABB_CCDD, 0, n);
        run_txn(0, 0, 32'h7A00_0020, 4'h0, 32'd0, 0, n);
        settle();
        chk("t2_rdd", h_rdd[n+4], 32'h11BB_33DD);

        // Out-of-window read.
        run_txn(0, 0, 32'h7B00_0000, 4'h0, 32'd0, 0, n);
        settle();
        chk("t3_ack_n1", h_ack[n+1], 1);
        chk("t3_cmplt_n2", h_cmplt[n+2], 1);
        chk("t3_err_n2", h_err[n+2], 1);
        for (int i = 0; i < 3; i++) chk("t3_no_src", h_src[n+i], 1);
        chk("t3_errcnt", stat_err_cnt, 1);

        // Misaligned write leaves the bank alone.
        run_txn(1, 0, 32'h7A00_0002, 4'hF, 32'hFFFF_FFFF, 0, n);
        settle();
        chk("t4_err_n2", h_err[n+2], 1);
        run_txn(0, 0, 32'h7A00_0000, 4'h0, 32'd0, 0, n);
        settle();
        chk("t4_rdd", h_rdd[n+4], 32'd0);

        // Simultaneous read and write requests: write first, held read next.
        run_txn(1, 1, 32'h7A00_000C, 4'hF, 32'h0000_0005, 0, n);
        settle();
        chk("t5_wr_first_dst", h_dst[n+4], 0);
        chk("t5_wr_first_src", h_src[n+4], 1);
        n2 = cyc;
        free_cyc = sched(0, 32'h7A00_000C, 4'h0, 32'd0, n2, 0);
        tick();
        bus_if.IP2Bus_MstRd_Req = 1'b0;
        settle();
        chk("t5_rd_ack", h_ack[n2+1], 1);
        chk("t5_rdd", h_rdd[n2+4], 32'h0000_0005);

        // Abort a write in WAIT; next request is acknowledged one cycle later.
        run_txn(1, 0, 32'h7A00_0030, 4'hF, 32'h1234_5678, 2, n);
        run_txn(0, 0, 32'h7A00_0030, 4'h0, 32'd0, 0, n2);
        settle();
        chk("t6_ack_next", h_ack[n+4], 1);
        chk("t6_no_dst", h_dst[n+4], 1);
        chk("t6_no_cmplt", h_cmplt[n+5], 0);
        chk("t6_rdd", h_rdd[n2+4], 32'd0);
        chk("t6_wrcnt", stat_wr_cnt, 4);
        chk("t6_rdcnt", stat_rd_cnt, 5);
        chk("t6_errcnt", stat_err_cnt, 2);

        // Random traffic.
        for (int t = 0; t < 200; t++) begin
            settle();
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
            wr  = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 15);
            r   = $urandom_range(0, 9);
            a   = BASE | (32'(idx) << 2);
            if (r == 8) a = a | 32'($urandom_range(1, 3));
            else if (r == 9) a = $urandom;
            ab = 0;
            if ($urandom_range(0, 9) == 0)
                ab = addr_ok(a) ? $urandom_range(1, 1 + W) : 1;
            run_txn(wr, 0, a, 4'($urandom), $urandom, ab, n);
        end
        settle();

        // Asynchronous reset in the middle of a DATA cycle.
        run_txn(1, 0, 32'h7A00_0040, 4'hF, 32'hDEAD_BEEF, 0, n);
        run_txn(0, 0, 32'h7A00_0040, 4'h0, 32'd0, 0, n);
        while (cyc < n + 4) tick();
        chk("t7_in_data", bus_if.Bus2IP_MstRd_src_rdy_n, 0);
        chk_en = 1'b0;
        #2;
        axi_resetn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        for (int i = cyc - 1; i < MAXC; i++) begin
            e_ack[i] = 0; e_cmplt[i] = 0; e_err[i] = 0; e_src[i] = 0; e_dst[i] = 0;
            e_inc_rd[i] = 0; e_inc_wr[i] = 0; e_inc_err[i] = 0;
        end
        for (int i = 0; i < DEPTH; i++) mmem[i] = 32'd0;
        m_rd = '0; m_wr = '0; m_err = '0; m_rdd = 32'd0;
        tick();
        tick();
        axi_resetn = 1'b1;
        free_cyc = cyc;
        chk_en = 1'b1;
        run_txn(0, 0, 32'h7A00_0040, 4'h0, 32'd0, 0, n);
        settle();
        chk("t7_src", h_src[n+4], 0);
        chk("t7_bank_cleared", h_rdd[n+4], 32'd0);

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ipif_mst_responder.md
Name: ipif_mst_responder

Overview:
- Single-beat responder (slave) for the 32-bit IPIF master command interface driven by the DMA engine's AXI-lite master port.
- Answers read and write requests from a local register bank of 2**ADDR_WIDTH words, with programmable wait latency and error signalling for bad addresses.
- Used as the bench/bring-up target for the DMA register path, and as a standalone scratch/config bank on the axi_clk domain.

Parameters:
- ADDR_WIDTH, 6: word-index width; bank holds 2**ADDR_WIDTH 32-bit registers.
- BASE_ADDR, 32'h7A00_0000: byte base of decode window; must be aligned to 2**(ADDR_WIDTH+2).
- WAIT_CYCLES, 2: wait cycles between CmdAck and data phase; legal range 0..15.
- CNT_WIDTH, 16: width of statistics counters.

Ports:
- axi_clk  in  1  sole clock; all logic rising-edge.
- axi_resetn  in  1  asynchronous, active-low reset.
- IP2Bus_MstRd_Req  in  1  read request; master holds it until CmdAck.
- IP2Bus_MstWr_Req  in  1  write request; master holds it until CmdAck.
- IP2Bus_Mst_Addr  in  32  byte address.
- IP2Bus_Mst_BE  in  4  byte enables, write only.
- IP2Bus_Mst_Lock  in  1  ignored.
- IP2Bus_Mst_Reset  in  1  master abort; active high.
- IP2Bus_MstWr_d  in  32  write data.
- Bus2IP_Mst_CmdAck  out  1  command accepted, 1-cycle pulse.
- Bus2IP_Mst_Cmplt  out  1  transaction complete, 1-cycle pulse.
- Bus2IP_Mst_Error  out  1  qualified by Cmplt.
- Bus2IP_Mst_Rearbitrate  out  1  constant 0.
- Bus2IP_Mst_Timeout  out  1  constant 0.
- Bus2IP_MstRd_d  out  32  read data.
- Bus2IP_MstRd_src_rdy_n  out  1  read data valid, active low.
- Bus2IP_MstWr_dst_rdy_n  out  1  write data taken, active low.
- stat_rd_cnt  out  CNT_WIDTH  completed good reads.
- stat_wr_cnt  out  CNT_WIDTH  completed good writes.
- stat_err_cnt  out  CNT_WIDTH  error completions.

Behaviour:
- Reset (axi_resetn=0, async):
  - FSM goes to IDLE.
  - CmdAck, Cmplt and Error = 0; src_rdy_n and dst_rdy_n = 1; Rd_d = 0.
  - All counters = 0; all bank registers = 0.
- FSM states: IDLE, ACK, WAIT, DATA, CMPLT.
- IDLE:
  - If either request is high, latch addr, BE and direction, then go to ACK.
  - If both requests are high in the same cycle, the write wins; the read stays pending and is served next.
- ACK: CmdAck=1 for one cycle.
  - If address is good, go to WAIT (or to DATA if WAIT_CYCLES=0).
  - If address is bad, go directly to CMPLT.
- Address decode:
  - Good when addr[31:ADDR_WIDTH+2]==BASE_ADDR[31:ADDR_WIDTH+2] and addr[1:0]==0.
  - Index = addr[ADDR_WIDTH+1:2].
  - Anything else is an error.
- WAIT: 4-bit down-counter loaded with WAIT_CYCLES-1 on ACK exit; go to DATA when it reaches 0.
- DATA, one cycle:
  - Read: src_rdy_n=0 and Rd_d=bank[index].
  - Write: dst_rdy_n=0 and IP2Bus_MstWr_d is sampled that cycle; only bytes with BE[i]=1 are updated.
  - Rd_d holds its value after DATA.
- CMPLT: Cmplt=1 for one cycle, Error=1 if the address was bad, then go to IDLE.
  - No new request is accepted in the CMPLT cycle; the earliest next CmdAck is 2 cycles after Cmplt.
- Counter updates in CMPLT:
  - stat_rd_cnt increments on a good read; stat_wr_cnt increments on a good write; stat_err_cnt increments on an error.
  - All counters wrap modulo 2**CNT_WIDTH.
- Latency: request first high in IDLE at cycle N gives:
  - CmdAck at N+1.
  - DATA at N+2+WAIT_CYCLES.
  - Cmplt at N+3+WAIT_CYCLES.
  - Error path: Cmplt at N+2.
- IP2Bus_Mst_Reset=1, any state:
  - Next cycle the FSM is in IDLE and all strobes are deasserted.
  - No Cmplt is issued and no counter changes.
  - A write is committed only if its DATA cycle has already passed.
  - Requests are ignored while Reset is high.
- Request dropped before CmdAck: ignored; the latched transaction proceeds normally.
- Lock is ignored; Rearbitrate and Timeout are never asserted.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - Write 32'hCAFE_F00D, BE=4'hF, to 32'h7A00_0010; request at cycle 0 -> CmdAck@1, dst_rdy_n low@4, Cmplt@5, Error=0.
  - Read the same address -> src_rdy_n low with Rd_d=32'hCAFE_F00D; stat_wr_cnt=1, stat_rd_cnt=1.
- Partial write: preload 32'h1122_3344, write 32'hAABB_CCDD with BE=4'b0101 -> readback 32'h11BB_33DD.
- Out-of-window read at 32'h7B00_0000 -> CmdAck@1, Cmplt+Error@2, no src_rdy_n pulse; stat_err_cnt=1.
- Misaligned write at 32'h7A00_0002 -> Error, and the bank is unchanged.
- Simultaneous Rd_Req and Wr_Req to index 3 (write data 32'h5) -> write completes first, then the read returns 32'h5.
- Abort: assert IP2Bus_Mst_Reset in WAIT of a write -> no dst_rdy_n, no Cmplt, bank and counters unchanged, next request gets CmdAck 1 cycle after being presented.
- Async reset mid-DATA -> all outputs at reset values immediately, bank cleared.
